// File: rtl/mfp_ahb_intc_pkg.sv
// Shared constants and types for the AHB-Lite interrupt controller (mfp_ahb_intc).
// Register word offsets, intc address region, and the latched data-phase payload.
package mfp_ahb_intc_pkg;

  localparam int unsigned REG_IDX_W      = 3;
  localparam int unsigned MFP_N_INTC_SRC = 16;

  localparam logic [REG_IDX_W-1:0] MFP_INTC_RAW    = 3'd0;
  localparam logic [REG_IDX_W-1:0] MFP_INTC_PEND   = 3'd1;
  localparam logic [REG_IDX_W-1:0] MFP_INTC_ENABLE = 3'd2;
  localparam logic [REG_IDX_W-1:0] MFP_INTC_EDGE   = 3'd3;
  localparam logic [REG_IDX_W-1:0] MFP_INTC_POL    = 3'd4;
  localparam logic [REG_IDX_W-1:0] MFP_INTC_VECTOR = 3'd5;
  localparam logic [REG_IDX_W-1:0] MFP_INTC_RSVD   = 3'd6;
  localparam logic [REG_IDX_W-1:0] MFP_INTC_SWTRIG = 3'd7;

  // 32-byte intc window in the system address map
  localparam logic [31:0] MFP_INTC_BASE = 32'h1f80_0800;

  function automatic logic mfp_intc_hsel(input logic [31:0] haddr);
    return haddr[31:5] == MFP_INTC_BASE[31:5];
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 write;
    logic                 size_ok;
    logic [REG_IDX_W-1:0] idx;
  } ahb_dp_t;

endpackage

// File: rtl/mfp_intc_sync.sv
// Per-source synchroniser with polarity adjust and rising-edge detect of the
// polarity-adjusted condition.
module mfp_intc_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic pol,
  output logic cond_c,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cond_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cond_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      cond_d <= cond_c;
    end
  end

  // A POL flip also toggles cond, so it can produce a latched edge
  assign cond_c = sync_q[SYNC_STAGES-1] ^ pol;
  assign rise_c = cond_c & ~cond_d;

endmodule

// File: rtl/mfp_ahb_intc.sv
// AHB-Lite interrupt controller driving the core SI_Int pins.
// Optional software trigger register at 0x1C enabled by `define MFP_INTC_SWTRIG_EN.
module mfp_ahb_intc
  import mfp_ahb_intc_pkg::*;
#(
  parameter int unsigned N_SRC       = 16,
  parameter int unsigned N_OUT       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             SI_Reset,
  input  logic             HSEL,
  input  logic [4:0]       HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  input  logic [N_SRC-1:0] IN_irq,
  output logic [N_OUT-1:0] SI_Int,
  output logic             OUT_irq_any
);

  ahb_dp_t          dp_q;
  logic [N_SRC-1:0] pend_q, enable_q, edge_q, pol_q;
  logic [N_SRC-1:0] cond_c, rise_c, w1c_c, sw_c, pend_n, act_c, wdata_c;
  logic [N_OUT-1:0] out_map_c;
  logic             wr_c;
  logic             unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign unused_ok = &{1'b0, HADDR[1:0], HTRANS[0], HWDATA};

  for (genvar i = 0; i < int'(N_SRC); i++) begin : g_sync
    mfp_intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (HCLK),
      .rst    (SI_Reset),
      .irq    (IN_irq[i]),
      .pol    (pol_q[i]),
      .cond_c (cond_c[i]),
      .rise_c (rise_c[i])
    );
  end

  // Address phase capture; offset is kept after the transfer for read data
  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      dp_q <= '0;
    end else if (HSEL && HTRANS[1]) begin
      dp_q.valid   <= 1'b1;
      dp_q.write   <= HWRITE;
      dp_q.size_ok <= (HSIZE == 3'b010);
      dp_q.idx     <= HADDR[4:2];
    end else begin
      dp_q.valid <= 1'b0;
    end
  end

  assign wr_c    = dp_q.valid & dp_q.write & dp_q.size_ok;
  assign wdata_c = HWDATA[N_SRC-1:0];
  assign w1c_c   = (wr_c && dp_q.idx == MFP_INTC_PEND) ? wdata_c : '0;

`ifdef MFP_INTC_SWTRIG_EN
  assign sw_c = (wr_c && dp_q.idx == MFP_INTC_SWTRIG) ? wdata_c : '0;
`else
  assign sw_c = '0;
`endif

  // Edge sources: set beats W1C; level sources follow cond
  assign pend_n = (edge_q & (rise_c | sw_c | (pend_q & ~w1c_c))) | (~edge_q & cond_c);
  assign act_c  = pend_q & enable_q;

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      pend_q   <= '0;
      enable_q <= '0;
      edge_q   <= '0;
      pol_q    <= '0;
    end else begin
      pend_q <= pend_n;
      if (wr_c && dp_q.idx == MFP_INTC_ENABLE) enable_q <= wdata_c;
      if (wr_c && dp_q.idx == MFP_INTC_EDGE)   edge_q   <= wdata_c;
      if (wr_c && dp_q.idx == MFP_INTC_POL)    pol_q    <= wdata_c;
    end
  end

  always_comb begin
    out_map_c = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      for (int i = k; i < int'(N_SRC); i += int'(N_OUT)) begin
        out_map_c[k] = out_map_c[k] | act_c[i];
      end
    end
  end

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      SI_Int      <= '0;
      OUT_irq_any <= 1'b0;
    end else begin
      SI_Int      <= out_map_c;
      OUT_irq_any <= |act_c;
    end
  end

  // Lowest-index qualifying source wins
  function automatic logic [31:0] prio_vec(input logic [N_SRC-1:0] v);
    prio_vec = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (v[i]) prio_vec = {1'b1, 26'b0, 5'(i)};
    end
  endfunction

  always_comb begin
    HRDATA = '0;
    case (dp_q.idx)
      MFP_INTC_RAW:    HRDATA = 32'(cond_c);
      MFP_INTC_PEND:   HRDATA = 32'(pend_q);
      MFP_INTC_ENABLE: HRDATA = 32'(enable_q);
      MFP_INTC_EDGE:   HRDATA = 32'(edge_q);
      MFP_INTC_POL:    HRDATA = 32'(pol_q);
      MFP_INTC_VECTOR: HRDATA = prio_vec(act_c);
      default:         HRDATA = '0;
    endcase
  end

endmodule
